xvc_shift_ctrl: RTL and testbench



---
 rtl/xvc_shift_ctrl.sv | 171 +++++++++++++++++
 tb/tb_xvc_shift_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xvc_shift_ctrl.sv
// rtl/xvc_shift_ctrl.sv - JTAG vector shift controller driving TCK/TMS/TDI and capturing TDO
module xvc_shift_ctrl (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        start,
    input  logic [5:0]  length,
    input  logic [31:0] tms_vec,
    input  logic [31:0] tdi_vec,
    input  logic [7:0]  clk_div,
    output logic        busy,
    output logic        done,
    output logic [31:0] tdo_vec,
    output logic        tck,
    output logic        tms,
    output logic        tdi,
    input  logic        tdo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  len_q, len_d;
    logic [31:0] tms_vec_q, tms_vec_d;
    logic [31:0] tdi_vec_q, tdi_vec_d;
    logic [7:0]  div_q, div_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [4:0]  idx_q, idx_d;
    logic [31:0] tdo_vec_q, tdo_vec_d;
    logic        tck_q, tck_d;
    logic        tms_q, tms_d;
    logic        tdi_q, tdi_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // Requests longer than the 32-bit vectors are clamped to a full-width shift
    logic [5:0]  len_eff;
    logic [4:0]  idx_nxt;
    logic        last_bit;

    assign len_eff  = (length > 6'd32) ? 6'd32 : length;
    assign idx_nxt  = idx_q + 5'd1;
    assign last_bit = ({1'b0, idx_q} == (len_q - 6'd1));

    // Next-state and registered-output computation for the shift sequencer
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        tms_vec_d = tms_vec_q;
        tdi_vec_d = tdi_vec_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        tdo_vec_d = tdo_vec_q;
        tck_d     = tck_q;
        tms_d     = tms_q;
        tdi_d     = tdi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d     = len_eff;
                    tms_vec_d = tms_vec;
                    tdi_vec_d = tdi_vec;
                    div_d     = clk_div;
                    cnt_d     = clk_div;
                    idx_d     = 5'd0;
                    tdo_vec_d = 32'd0;
                    tck_d     = 1'b0;
                    if (len_eff == 6'd0) begin
                        // Nothing to shift: report completion straight away
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_LOW;
                        busy_d  = 1'b1;
                        tms_d   = tms_vec[0];
                        tdi_d   = tdi_vec[0];
                    end
                end
            end

            S_LOW: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_HIGH;
                    tck_d   = 1'b1;
                    cnt_d   = div_q;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            S_HIGH: begin
                if (cnt_q == 8'd0) begin
                    // Sample TDO at the end of the high phase, just before the falling edge
                    tdo_vec_d[idx_q] = tdo;
                    tck_d            = 1'b0;
                    if (!last_bit) begin
                        state_d = S_LOW;
                        idx_d   = idx_nxt;
                        cnt_d   = div_q;
                        tms_d   = tms_vec_q[idx_nxt];
                        tdi_d   = tdi_vec_q[idx_nxt];
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q   <= S_IDLE;
            len_q     <= 6'd0;
            tms_vec_q <= 32'd0;
            tdi_vec_q <= 32'd0;
            div_q     <= 8'd0;
            cnt_q     <= 8'd0;
            idx_q     <= 5'd0;
            tdo_vec_q <= 32'd0;
            tck_q     <= 1'b0;
            tms_q     <= 1'b0;
            tdi_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            tms_vec_q <= tms_vec_d;
            tdi_vec_q <= tdi_vec_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            tdo_vec_q <= tdo_vec_d;
            tck_q     <= tck_d;
            tms_q     <= tms_d;
            tdi_q     <= tdi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign tdo_vec = tdo_vec_q;
    assign tck     = tck_q;
    assign tms     = tms_q;
    assign tdi     = tdi_q;

endmodule

// File: tb/tb_xvc_shift_ctrl.sv
// tb/tb_xvc_shift_ctrl.sv - self-checking bench for xvc_shift_ctrl
module tb_xvc_shift_ctrl;

    logic        ACLK;
    logic        ARESETN;
    logic        start;
    logic [5:0]  length;
    logic [31:0] tms_vec;
    logic [31:0] tdi_vec;
    logic [7:0]  clk_div;
    logic        busy;
    logic        done;
    logic [31:0] tdo_vec;
    logic        tck;
    logic        tms;
    logic        tdi;
    logic        tdo;

    int tdo_mode;  // 0: tied low, 1: tied high, 2: loopback of tdi

    xvc_shift_ctrl dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .start   (start),
        .length  (length),
        .tms_vec (tms_vec),
        .tdi_vec (tdi_vec),
        .clk_div (clk_div),
        .busy    (busy),
        .done    (done),
        .tdo_vec (tdo_vec),
        .tck     (tck),
        .tms     (tms),
        .tdi     (tdi),
        .tdo     (tdo)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    always_comb begin
        tdo = 1'b0;
        if (tdo_mode == 1) tdo = 1'b1;
        else if (tdo_mode == 2) tdo = tdi;
    end

    typedef struct {
        logic [5:0]  len;
        logic [31:0] tms_v;
        logic [31:0] tdi_v;
        logic [7:0]  div;
        int          mode;
        int          inject;
        logic [31:0] exp_tdo;
    } vec_t;

    typedef struct {
        logic [31:0] tdo;
        int          done_c;
        int          n;
        int          busy_n;
        logic [31:0] tms_m;
        logic [31:0] tdi_m;
        logic        tms_idle;
        logic        tdi_idle;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt;
    int   chk_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        chk_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    endtask

    task automatic run_shift(input vec_t v, input string tag);
        exp_t        e;
        exp_t        got;
        int          n;
        int          first_done;
        int          dones;
        int          busy_n;
        int          rises;
        logic        prev_tck;
        logic [31:0] tms_seen;
        logic [31:0] tdi_seen;
        logic [63:0] m64;
        logic [31:0] mask;
        logic [31:0] tv;
        logic [31:0] dv;

        n    = (v.len > 6'd32) ? 32 : int'(v.len);
        m64  = (64'd1 << n) - 64'd1;
        mask = m64[31:0];
        tv   = v.tms_v;
        dv   = v.tdi_v;
        e.tdo    = v.exp_tdo;
        e.n      = n;
        e.busy_n = 2 * n * (int'(v.div) + 1);
        e.done_c = e.busy_n + 1;
        e.tms_m  = tv & mask;
        e.tdi_m  = dv & mask;
        e.tms_idle = (n > 0) ? tv[n-1] : tms;
        e.tdi_idle = (n > 0) ? dv[n-1] : tdi;

        tdo_mode = v.mode;
        length   = v.len;
        tms_vec  = v.tms_v;
        tdi_vec  = v.tdi_v;
        clk_div  = v.div;
        start    = 1'b1;
        sb.push_back(e);
        prev_tck = tck;

        @(posedge ACLK);
        #1;
        start   = 1'b0;
        length  = 6'($urandom);
        tms_vec = $urandom;
        tdi_vec = $urandom;
        clk_div = 8'($urandom);

        first_done = 0;
        dones      = 0;
        busy_n     = 0;
        rises      = 0;
        tms_seen   = 32'd0;
        tdi_seen   = 32'd0;
        for (int c = 1; c <= e.done_c + 40; c++) begin
            if (c > 1) begin
                @(posedge ACLK);
                #1;
            end
            if (done) begin
                dones++;
                if (first_done == 0) first_done = c;
            end
            if (busy) busy_n++;
            if (tck && !prev_tck) begin
                if (rises < 32) begin
                    tms_seen[rises] = tms;
                    tdi_seen[rises] = tdi;
                end
                rises++;
            end
            prev_tck = tck;
            if (c == v.inject) begin
                start   = 1'b1;
                length  = 6'd2;
                tms_vec = ~v.tms_v;
                tdi_vec = ~v.tdi_v;
                clk_div = 8'd0;
            end else begin
                start = 1'b0;
            end
        end

        got = sb.pop_front();
        check({tag, ".done_cycle"}, 64'(first_done), 64'(got.done_c));
        check({tag, ".done_pulses"}, 64'(dones), 64'd1);
        check({tag, ".tdo_vec"}, 64'(tdo_vec), 64'(got.tdo));
        check({tag, ".busy_cycles"}, 64'(busy_n), 64'(got.busy_n));
        check({tag, ".tck_rises"}, 64'(rises), 64'(got.n));
        check({tag, ".tms_seq"}, 64'(tms_seen), 64'(got.tms_m));
        check({tag, ".tdi_seq"}, 64'(tdi_seen), 64'(got.tdi_m));
        check({tag, ".idle_hold"}, {60'd0, tck, busy, tms, tdi}, {60'd0, 1'b0, 1'b0, got.tms_idle, got.tdi_idle});
    endtask

    vec_t tbl[9];
    vec_t v2;
    int   rises;
    logic prev_tck;
    int   dones;
    bit   hit;

    initial begin
        pass_cnt = 0;
        chk_cnt  = 0;
        tdo_mode = 0;
        ARESETN  = 1'b0;
        start    = 1'b0;
        length   = 6'd0;
        tms_vec  = 32'd0;
        tdi_vec  = 32'd0;
        clk_div  = 8'd0;

        //            len     tms_v          tdi_v          div     mode inj  exp_tdo
        tbl[0] = '{6'd4,  32'h0000_0005, 32'h0000_000A, 8'd0,   2, 0, 32'h0000_000A};
        tbl[1] = '{6'd32, 32'hC3A5_0F96, 32'h1234_5678, 8'd3,   1, 0, 32'hFFFF_FFFF};
        tbl[2] = '{6'd0,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd2,   1, 0, 32'h0000_0000};
        tbl[3] = '{6'd40, 32'h1234_5678, 32'h9ABC_DEF0, 8'd1,   2, 0, 32'h9ABC_DEF0};
        tbl[4] = '{6'd1,  32'h0000_0001, 32'h0000_0001, 8'd2,   2, 0, 32'h0000_0001};
        tbl[5] = '{6'd7,  32'h0000_0055, 32'h0000_006B, 8'd0,   0, 0, 32'h0000_0000};
        tbl[6] = '{6'd8,  32'h0000_00A5, 32'h0000_003C, 8'd1,   2, 3, 32'h0000_003C};
        tbl[7] = '{6'd17, 32'h0F0F_0F0F, 32'hDEAD_BEEF, 8'd0,   2, 0, 32'h0001_BEEF};
        tbl[8] = '{6'd1,  32'h0000_0000, 32'h0000_0001, 8'd255, 1, 0, 32'h0000_0001};

        repeat (3) @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
        check("reset.outputs", {58'd0, busy, done, tck, tms, tdi, 1'b0}, 64'd0);
        check("reset.tdo_vec", 64'(tdo_vec), 64'd0);

        for (int t = 0; t < 9; t++) begin
            run_shift(tbl[t], $sformatf("vec%0d", t));
        end

        // Abort a length-16 shift during the high phase of bit 5
        tdo_mode = 1;
        length   = 6'd16;
        tms_vec  = 32'h0000_FFFF;
        tdi_vec  = 32'h0000_AAAA;
        clk_div  = 8'd1;
        start    = 1'b1;
        prev_tck = tck;
        @(posedge ACLK);
        #1;
        start = 1'b0;
        rises = 0;
        hit   = 1'b0;
        for (int c = 0; c < 500 && !hit; c++) begin
            if (tck && !prev_tck) rises++;
            prev_tck = tck;
            if (rises == 6) hit = 1'b1;
            else begin
                @(posedge ACLK);
                #1;
            end
        end
        check("abort.reached_bit5_high", {63'd0, hit}, 64'd1);
        check("abort.pre_reset_tdo_vec", 64'(tdo_vec), 64'h1F);
        ARESETN = 1'b0;
        @(posedge ACLK);
        #1;
        check("abort.after_reset", {59'd0, tck, busy, done, tms, tdi}, 64'd0);
        check("abort.tdo_vec", 64'(tdo_vec), 64'd0);
        ARESETN = 1'b1;
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge ACLK);
            #1;
            if (done || busy || tck) dones++;
        end
        check("abort.quiet_after_release", 64'(dones), 64'd0);

        v2 = '{6'd2, 32'h0000_0002, 32'h0000_0001, 8'd0, 2, 0, 32'h0000_0001};
        run_shift(v2, "post_reset");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
